// File: rtl/arb_req_agent_if.sv
// arb_req_agent_if: job handshake, arbiter request/grant and fault flags of the requester agent
interface arb_req_agent_if #(
   parameter int LEN_W = 4
);
   logic [2:0] job_valid, job_ready, r, g, done, err_lost, err_timeout, err_spur;
   logic [3*LEN_W-1:0] job_len;
   logic err_multi;
   modport master (
      input job_valid, job_len, g,
      output job_ready, r, done, err_lost, err_timeout, err_spur, err_multi
   );
   modport slave (
      output job_valid, job_len, g,
      input job_ready, r, done, err_lost, err_timeout, err_spur, err_multi
   );
endinterface

// File: rtl/arb_req_agent.sv
// arb_req_agent: three per-client request FSMs driving arbiter r lines and checking its g lines
module arb_req_agent #(
   parameter int LEN_W = 4,
   parameter int WAIT_MAX = 16
) (
   input logic clk,
   input logic reset,
   arb_req_agent_if.master bus
);
   localparam int WW = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;
   typedef enum logic [1:0] {IDLE, REQ, OWN, GAP} state_t;
   state_t state [3];
   state_t state_n [3];
   logic [LEN_W-1:0] cnt [3];
   logic [LEN_W-1:0] cnt_n [3];
   logic [LEN_W-1:0] len [3];
   logic [WW-1:0] wcnt [3];
   logic [WW-1:0] wcnt_n [3];
   logic [2:0] done_n, lost_n, to_n, spur_n;
   logic multi;
   assign multi = (bus.g[0] & bus.g[1]) | (bus.g[0] & bus.g[2]) | (bus.g[1] & bus.g[2]);
   always_comb begin
      done_n = '0;
      lost_n = '0;
      to_n = '0;
      spur_n = '0;
      bus.r = '0;
      bus.job_ready = '0;
      for (int i = 0; i < 3; i++) begin
         state_n[i] = state[i];
         cnt_n[i] = cnt[i];
         wcnt_n[i] = wcnt[i];
         len[i] = bus.job_len[i*LEN_W +: LEN_W];
         bus.r[i] = state[i] == REQ || state[i] == OWN;
         bus.job_ready[i] = state[i] == IDLE;
         // cnt holds L-1 from accept onward, so no separate length register is needed
         case (state[i])
            IDLE: begin
               spur_n[i] = bus.g[i];
               if (bus.job_valid[i]) begin
                  state_n[i] = REQ;
                  cnt_n[i] = len[i] == '0 ? '0 : len[i] - 1'b1;
                  wcnt_n[i] = '0;
               end
            end
            REQ:
               if (bus.g[i]) state_n[i] = OWN;
               else if (WAIT_MAX != 0 && wcnt[i] == WW'(WAIT_MAX - 1)) begin
                  state_n[i] = GAP;
                  to_n[i] = 1'b1;
               end else wcnt_n[i] = wcnt[i] + 1'b1;
            OWN:
               if (!bus.g[i]) begin
                  state_n[i] = GAP;
                  lost_n[i] = 1'b1;
               end else if (cnt[i] == '0) begin
                  state_n[i] = GAP;
                  done_n[i] = 1'b1;
               end else cnt_n[i] = cnt[i] - 1'b1;
            default: state_n[i] = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         state[i] <= reset ? IDLE : state_n[i];
         cnt[i] <= reset ? '0 : cnt_n[i];
         wcnt[i] <= reset ? '0 : wcnt_n[i];
      end
      bus.done <= reset ? '0 : done_n;
      bus.err_lost <= reset ? '0 : bus.err_lost | lost_n;
      bus.err_timeout <= reset ? '0 : bus.err_timeout | to_n;
      bus.err_spur <= reset ? '0 : bus.err_spur | spur_n;
      bus.err_multi <= reset ? 1'b0 : bus.err_multi | multi;
   end
endmodule

// File: tb/tb_arb_req_agent.sv
// tb_arb_req_agent: directed checks of the agent against a registered 0>1>2 priority arbiter model
module tb_arb_req_agent;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [2:0] arb_g = 3'b000;
   logic [2:0] force_g = 3'b000;
   logic [2:0] g4 = 3'b000;
   logic force_en = 1'b0;
   int vec = 0;
   int bad = 0;
   arb_req_agent_if #(.LEN_W(4)) bus ();
   arb_req_agent_if #(.LEN_W(4)) bus4 ();
   arb_req_agent #(.LEN_W(4), .WAIT_MAX(16)) u0 (.clk(clk), .reset(reset), .bus(bus));
   arb_req_agent #(.LEN_W(4), .WAIT_MAX(4)) u1 (.clk(clk), .reset(reset), .bus(bus4));
   always #5 clk = ~clk;
   assign bus.g = force_en ? force_g : arb_g;
   assign bus4.g = g4;
   // arbiter keeps the current owner while it still requests, else picks the lowest index
   always @(posedge clk)
      if (reset) arb_g <= 3'b000;
      else if ((arb_g & bus.r) != 3'b000) arb_g <= arb_g;
      else arb_g <= bus.r[0] ? 3'b001 : bus.r[1] ? 3'b010 : bus.r[2] ? 3'b100 : 3'b000;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      reset = 1'b1;
      tick;
      reset = 1'b0;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      bus.job_valid = 3'b111;
      bus.job_len = '0;
      tick;
      tick;
      vec++; if ({bus.r, bus.done} !== 6'b0) begin bad++; $display("FAIL reset_r_done got %b want %b", {bus.r, bus.done}, 6'b0); end
      vec++; if (bus.job_ready !== 3'b111) begin bad++; $display("FAIL reset_ready got %b want %b", bus.job_ready, 3'b111); end
      vec++; if ({bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi} !== 10'b0) begin bad++; $display("FAIL reset_err got %b want %b", {bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi}, 10'b0); end
      reset = 1'b0;
      tick;
      vec++; if ({bus.r, bus.job_ready} !== 6'b111_000) begin bad++; $display("FAIL reset_first_accept got %b want %b", {bus.r, bus.job_ready}, 6'b111_000); end
      bus.job_valid = 3'b000;
      do_reset;
   endtask
   task automatic test_single;
      logic [8:0] exp [7];
      exp = '{9'b010_000_101, 9'b010_000_101, 9'b010_000_101, 9'b010_000_101, 9'b010_000_101, 9'b000_010_101, 9'b000_000_111};
      bus.job_len = 12'h030;
      bus.job_valid = 3'b010;
      tick;
      bus.job_valid = 3'b000;
      for (int k = 0; k < 7; k++) begin
         if (k != 0) tick;
         vec++; if ({bus.r, bus.done, bus.job_ready} !== exp[k]) begin bad++; $display("FAIL single cyc%0d r_done_ready got %b want %b", k, {bus.r, bus.done, bus.job_ready}, exp[k]); end
      end
      vec++; if ({bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi} !== 10'b0) begin bad++; $display("FAIL single_err got %b want %b", {bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi}, 10'b0); end
   endtask
   task automatic test_contention;
      logic [8:0] exp [10];
      exp = '{9'b101_000_010, 9'b101_000_010, 9'b101_000_010, 9'b101_000_010, 9'b100_001_010,
              9'b100_000_011, 9'b100_000_011, 9'b100_000_011, 9'b000_100_011, 9'b000_000_111};
      bus.job_len = 12'h202;
      bus.job_valid = 3'b101;
      tick;
      bus.job_valid = 3'b000;
      for (int k = 0; k < 10; k++) begin
         if (k != 0) tick;
         vec++; if ({bus.r, bus.done, bus.job_ready} !== exp[k]) begin bad++; $display("FAIL contention cyc%0d r_done_ready got %b want %b", k, {bus.r, bus.done, bus.job_ready}, exp[k]); end
      end
      vec++; if ({bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi} !== 10'b0) begin bad++; $display("FAIL contention_err got %b want %b", {bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi}, 10'b0); end
   endtask
   task automatic test_timeout;
      logic [8:0] exp [6];
      exp = '{9'b100_000_000, 9'b100_000_000, 9'b100_000_000, 9'b100_000_000, 9'b000_100_000, 9'b000_100_000};
      bus4.job_len = 12'h300;
      bus4.job_valid = 3'b100;
      tick;
      bus4.job_valid = 3'b000;
      for (int k = 0; k < 6; k++) begin
         if (k != 0) tick;
         vec++; if ({bus4.r, bus4.err_timeout, bus4.done} !== exp[k]) begin bad++; $display("FAIL timeout cyc%0d r_to_done got %b want %b", k, {bus4.r, bus4.err_timeout, bus4.done}, exp[k]); end
      end
      vec++; if (bus4.job_ready !== 3'b111) begin bad++; $display("FAIL timeout_ready got %b want %b", bus4.job_ready, 3'b111); end
   endtask
   task automatic test_lost_reset;
      logic [8:0] exp [7];
      exp = '{9'b001_000_000, 9'b001_000_000, 9'b001_000_000, 9'b001_000_000, 9'b000_001_000, 9'b000_001_000, 9'b000_001_000};
      bus.job_len = 12'h005;
      bus.job_valid = 3'b001;
      tick;
      bus.job_valid = 3'b000;
      for (int k = 0; k < 7; k++) begin
         if (k != 0) tick;
         vec++; if ({bus.r, bus.err_lost, bus.done} !== exp[k]) begin bad++; $display("FAIL lost cyc%0d r_lost_done got %b want %b", k, {bus.r, bus.err_lost, bus.done}, exp[k]); end
         if (k == 3) begin force_g = 3'b000; force_en = 1'b1; end
         if (k == 4) force_en = 1'b0;
      end
      bus.job_len = 12'h040;
      bus.job_valid = 3'b010;
      tick;
      bus.job_valid = 3'b000;
      tick;
      tick;
      tick;
      vec++; if ({bus.r, bus.err_lost} !== 6'b010_001) begin bad++; $display("FAIL midjob_own r_lost got %b want %b", {bus.r, bus.err_lost}, 6'b010_001); end
      reset = 1'b1;
      tick;
      vec++; if ({bus.r, bus.done, bus.job_ready} !== 9'b000_000_111) begin bad++; $display("FAIL midjob_reset r_done_ready got %b want %b", {bus.r, bus.done, bus.job_ready}, 9'b000_000_111); end
      vec++; if ({bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi} !== 10'b0) begin bad++; $display("FAIL midjob_reset_err got %b want %b", {bus.err_lost, bus.err_timeout, bus.err_spur, bus.err_multi}, 10'b0); end
      reset = 1'b0;
   endtask
   task automatic test_grant_faults;
      force_g = 3'b011;
      force_en = 1'b1;
      tick;
      force_en = 1'b0;
      vec++; if ({bus.err_multi, bus.err_spur} !== 4'b1_011) begin bad++; $display("FAIL multi got %b want %b", {bus.err_multi, bus.err_spur}, 4'b1_011); end
      do_reset;
      force_g = 3'b010;
      force_en = 1'b1;
      tick;
      force_en = 1'b0;
      vec++; if ({bus.err_multi, bus.err_spur} !== 4'b0_010) begin bad++; $display("FAIL spur1 got %b want %b", {bus.err_multi, bus.err_spur}, 4'b0_010); end
      do_reset;
      bus.job_len = 12'h100;
      bus.job_valid = 3'b100;
      tick;
      bus.job_valid = 3'b000;
      tick;
      tick;
      tick;
      vec++; if ({bus.r, bus.done} !== 6'b000_100) begin bad++; $display("FAIL gap_entry r_done got %b want %b", {bus.r, bus.done}, 6'b000_100); end
      force_g = 3'b100;
      force_en = 1'b1;
      tick;
      force_en = 1'b0;
      vec++; if ({bus.err_spur, bus.r, bus.done} !== 9'b0) begin bad++; $display("FAIL gap_grant spur_r_done got %b want %b", {bus.err_spur, bus.r, bus.done}, 9'b0); end
      tick;
      vec++; if ({bus.err_spur, bus.job_ready} !== 6'b000_111) begin bad++; $display("FAIL gap_after spur_ready got %b want %b", {bus.err_spur, bus.job_ready}, 6'b000_111); end
   endtask
   initial begin
      bus.job_valid = 3'b000;
      bus.job_len = '0;
      bus4.job_valid = 3'b000;
      bus4.job_len = '0;
      test_reset;
      test_single;
      test_contention;
      test_timeout;
      test_lost_reset;
      test_grant_faults;
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
